// File: rtl/decode_issue_if.sv
// decode_issue_if -- the three bundles around the decoder.
//   fetch      : inst_valid, inst, inst_ready
//   write-back : wb_en, wb_rd, wb_data
//   issue      : ex_valid, ex_ready, ex_funct3, ex_funct7, ex_operand1,
//                ex_operand2, ex_rd
//   status     : illegal, issue_count
// modport slave is the decoder's view; modport master is the surrounding
// pipeline (fetch, write-back and ALU) that drives it.
interface decode_issue_if;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;

  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [31:0] ex_operand1;
  logic [31:0] ex_operand2;
  logic [4:0]  ex_rd;

  logic        illegal;
  logic [15:0] issue_count;

  modport master (
    output inst_valid, inst, wb_en, wb_rd, wb_data, ex_ready,
    input  inst_ready, ex_valid, ex_funct3, ex_funct7, ex_operand1,
           ex_operand2, ex_rd, illegal, issue_count
  );

  modport slave (
    input  inst_valid, inst, wb_en, wb_rd, wb_data, ex_ready,
    output inst_ready, ex_valid, ex_funct3, ex_funct7, ex_operand1,
           ex_operand2, ex_rd, illegal, issue_count
  );
endinterface

// File: rtl/decode_issue.sv
// decode_issue -- RV32 decode stage with register file and a one-entry issue
// register feeding the ALU.
//   CLK   : single clock, all state on the rising edge
//   RESET : synchronous, active-high; clears the issue register, counters
//           and all 32 architectural registers
//   bus   : decode_issue_if.slave (fetch, write-back, issue and status)
// Supported opcodes are OP (R-type) and OP-IMM. Any other opcode is accepted,
// dropped, and reported with a one-cycle illegal pulse. A write-back in the
// accept cycle is forwarded into the operands so no stale value is issued.
module decode_issue (
  input logic           CLK,
  input logic           RESET,
  decode_issue_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  logic [31:0] rf [32];

  logic        ex_valid_q;
  logic [2:0]  ex_funct3_q;
  logic [6:0]  ex_funct7_q;
  logic [31:0] ex_operand1_q;
  logic [31:0] ex_operand2_q;
  logic [4:0]  ex_rd_q;
  logic        illegal_q;
  logic [15:0] issue_count_q;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_sext;

  assign opcode   = bus.inst[6:0];
  assign rs1      = bus.inst[19:15];
  assign rs2      = bus.inst[24:20];
  assign funct3   = bus.inst[14:12];
  assign imm_sext = {{20{bus.inst[31]}}, bus.inst[31:20]};

  logic is_op;
  logic is_op_imm;
  logic supported;
  logic accept;

  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign supported = is_op || is_op_imm;

  // The issue register can take a new entry when empty or when its current
  // entry leaves this cycle; deliberately independent of inst_valid.
  assign bus.inst_ready = !ex_valid_q || bus.ex_ready;
  assign accept         = bus.inst_valid && bus.inst_ready && !RESET;

  // Source reads: x0 is hardwired to zero, and a same-cycle write-back to the
  // source wins over the array contents (it lands on this same edge).
  logic [31:0] src1;
  logic [31:0] src2;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    src1 = '0;
    if (rs1 != 5'd0) begin
      src1 = (bus.wb_en && (bus.wb_rd == rs1)) ? bus.wb_data : rf[rs1];
    end
  end

  always_comb begin
    src2 = '0;
    if (rs2 != 5'd0) begin
      src2 = (bus.wb_en && (bus.wb_rd == rs2)) ? bus.wb_data : rf[rs2];
    end
  end

  // Decoded funct7/operand2. Only the shift-immediates (funct3 001/101) carry
  // a meaningful funct7 in OP-IMM; elsewhere those bits are immediate bits.
  logic [6:0]  dec_funct7;
  logic [31:0] dec_operand2;

  always_comb begin
    dec_funct7   = '0;
    dec_operand2 = src2;
    if (is_op_imm) begin
      dec_operand2 = imm_sext;
      if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
        dec_funct7 = bus.inst[31:25];
      end
    end else begin
      dec_funct7 = bus.inst[31:25];
    end
  end

  // Register file. x0 is never written, so its entry stays at its reset value
  // and is never read anyway.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the register file is cleared in reset because the architecture
      // requires all 32 registers to read 0 afterwards; plain storage arrays
      // are normally left without reset.
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
      rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Issue register, illegal pulse and issue counter.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RESET) begin
      ex_valid_q    <= 1'b0;
      ex_funct3_q   <= '0;
      ex_funct7_q   <= '0;
      ex_operand1_q <= '0;
      ex_operand2_q <= '0;
      ex_rd_q       <= '0;
      illegal_q     <= 1'b0;
      issue_count_q <= '0;
    end else begin
      illegal_q <= accept && !supported;

      if (ex_valid_q && bus.ex_ready) begin
        issue_count_q <= issue_count_q + 16'd1;
      end

      // A supported accept overwrites the entry even while it is being
      // consumed, giving back-to-back issue with no bubble.
      if (accept && supported) begin
        ex_valid_q    <= 1'b1;
        ex_funct3_q   <= funct3;
        ex_funct7_q   <= dec_funct7;
        ex_operand1_q <= src1;
        ex_operand2_q <= dec_operand2;
        ex_rd_q       <= bus.inst[11:7];
      end else if (bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_funct3   = ex_funct3_q;
  assign bus.ex_funct7   = ex_funct7_q;
  assign bus.ex_operand1 = ex_operand1_q;
  assign bus.ex_operand2 = ex_operand2_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.illegal     = illegal_q;
  assign bus.issue_count = issue_count_q;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue -- self-checking bench for decode_issue. Every accepted
// supported instruction pushes its expected issue entry onto a scoreboard;
// a negedge monitor pops and compares whenever the ALU side consumes.
module tb_decode_issue;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  decode_issue_if bus ();

  decode_issue dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] regs_m [32];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] sw_count = '0;
  int          cyc = 0;
  exp_t        mon_e;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: value a source register should deliver in the accept cycle.
  function automatic logic [31:0] src_val(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_rd == r) return bus.wb_data;
    return regs_m[r];
  endfunction

  function automatic exp_t model_of(input logic [31:0] i);
    exp_t e;
    e.f3  = i[14:12];
    e.rd  = i[11:7];
    e.op1 = src_val(i[19:15]);
    if (i[6:0] == 7'b0110011) begin
      e.f7  = i[31:25];
      e.op2 = src_val(i[24:20]);
    end else begin
      e.f7  = (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? i[31:25] : 7'd0;
      e.op2 = {{20{i[31]}}, i[31:20]};
    end
    return e;
  endfunction

  function automatic bit is_supported(input logic [31:0] i);
    return (i[6:0] == 7'b0110011) || (i[6:0] == 7'b0010011);
  endfunction

  // Monitor: compare each consumed entry against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      sw_count = '0;
    end else if (bus.ex_valid && bus.ex_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_funct3", 32'(bus.ex_funct3), 32'(mon_e.f3));
        check("sb_funct7", 32'(bus.ex_funct7), 32'(mon_e.f7));
        check("sb_operand1", bus.ex_operand1, mon_e.op1);
        check("sb_operand2", bus.ex_operand2, mon_e.op2);
        check("sb_rd", 32'(bus.ex_rd), 32'(mon_e.rd));
        check("sb_issue_count", 32'(bus.issue_count), 32'(sw_count));
        sw_count = sw_count + 16'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction (plus whatever write-back is currently driven),
  // wait for acceptance, and return 1 time unit after the accept edge.
  task automatic issue(input logic [31:0] i);
    bit ok;
    ok = 1'b0;
    bus.inst       = i;
    bus.inst_valid = 1'b1;
    if (is_supported(i)) sb.push_back(model_of(i));
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.inst_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (bus.wb_en && bus.wb_rd != 5'd0) regs_m[bus.wb_rd] = bus.wb_data;
    bus.inst_valid = 1'b0;
    bus.wb_en      = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = r;
    bus.wb_data = d;
    tick();
    if (r != 5'd0) regs_m[r] = d;
    bus.wb_en = 1'b0;
  endtask

  task automatic drain();
    bus.ex_ready = 1'b1;
    repeat (2) tick();
  endtask

  localparam logic [31:0] ADD_3_1_2  = 32'h002081B3;
  localparam logic [31:0] ADD_3_0_2  = 32'h002001B3;
  localparam logic [31:0] ADD_6_5_0  = 32'h00028333;
  localparam logic [31:0] SUB_4_2_1  = 32'h40110233;
  localparam logic [31:0] ADDI_M1    = 32'hFFF08093;
  localparam logic [31:0] SRAI_3     = 32'h4030D093;
  localparam logic [31:0] ANDI_M32   = 32'hFE00F093;
  localparam logic [31:0] SLLI_5     = 32'h00509093;
  localparam logic [31:0] BEQ        = 32'h00000063;

  initial begin
    exp_t        ea;
    int          c0;
    logic [31:0] r;

    for (int k = 0; k < 32; k++) regs_m[k] = '0;

    // Reset with live inputs that must be ignored.
    reset          = 1'b1;
    bus.inst_valid = 1'b1;
    bus.inst       = ADD_3_1_2;
    bus.wb_en      = 1'b1;
    bus.wb_rd      = 5'd1;
    bus.wb_data    = 32'hFFFF_0000;
    bus.ex_ready   = 1'b0;
    repeat (3) tick();
    reset          = 1'b0;
    bus.inst_valid = 1'b0;
    bus.wb_en      = 1'b0;
    check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_issue_count", 32'(bus.issue_count), 32'd0);
    check("rst_inst_ready", 32'(bus.inst_ready), 32'd1);
    check("rst_operand1", bus.ex_operand1, 32'd0);

    // Basic R-type: x1=5, x2=7, add x3,x1,x2.
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    bus.ex_ready = 1'b1;
    issue(ADD_3_1_2);
    check("add_valid", 32'(bus.ex_valid), 32'd1);
    check("add_op1", bus.ex_operand1, 32'd5);
    check("add_op2", bus.ex_operand2, 32'd7);
    check("add_rd", 32'(bus.ex_rd), 32'd3);
    check("add_funct3", 32'(bus.ex_funct3), 32'd0);
    check("add_funct7", 32'(bus.ex_funct7), 32'd0);
    tick();
    check("add_count", 32'(bus.issue_count), 32'd1);
    check("add_cleared", 32'(bus.ex_valid), 32'd0);

    // OP-IMM immediates and funct7 rules.
    issue(ADDI_M1);
    check("addi_op2", bus.ex_operand2, 32'hFFFF_FFFF);
    check("addi_funct7", 32'(bus.ex_funct7), 32'd0);
    issue(SRAI_3);
    check("srai_funct7", 32'(bus.ex_funct7), 32'h20);
    check("srai_op2", bus.ex_operand2, 32'h0000_0403);
    check("srai_funct3", 32'(bus.ex_funct3), 32'd5);
    issue(ANDI_M32);
    check("andi_funct7", 32'(bus.ex_funct7), 32'd0);
    check("andi_op2", bus.ex_operand2, 32'hFFFF_FFE0);
    issue(SLLI_5);
    drain();

    // Backpressure: hold A for 4 cycles with B pending, then release.
    bus.ex_ready = 1'b0;
    ea = model_of(ADD_3_1_2);
    issue(ADD_3_1_2);
    bus.inst       = SUB_4_2_1;
    bus.inst_valid = 1'b1;
    sb.push_back(model_of(SUB_4_2_1));
    repeat (4) begin
      @(negedge clk);
      check("hold_inst_ready", 32'(bus.inst_ready), 32'd0);
      check("hold_valid", 32'(bus.ex_valid), 32'd1);
      check("hold_op1", bus.ex_operand1, ea.op1);
      check("hold_op2", bus.ex_operand2, ea.op2);
      check("hold_rd", 32'(bus.ex_rd), 32'(ea.rd));
    end
    @(posedge clk);
    #1;
    bus.ex_ready = 1'b1;
    tick();
    bus.inst_valid = 1'b0;
    check("b2b_valid", 32'(bus.ex_valid), 32'd1);
    check("b2b_rd", 32'(bus.ex_rd), 32'd4);
    check("b2b_funct7", 32'(bus.ex_funct7), 32'h20);
    drain();

    // Write-back bypass into the accept cycle.
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h1234_5678;
    issue(ADD_3_1_2);
    check("byp_op1", bus.ex_operand1, 32'h1234_5678);
    check("byp_op2", bus.ex_operand2, 32'd7);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEAD_BEEF;
    issue(ADD_3_0_2);
    check("byp_x0_op1", bus.ex_operand1, 32'd0);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h0BAD_F00D;
    issue(ADD_3_1_2);
    check("byp_op2_rs2", bus.ex_operand2, 32'h0BAD_F00D);
    check("byp_op1_regfile", bus.ex_operand1, 32'h1234_5678);
    drain();

    // Unsupported opcode while idle, then while consuming a held entry.
    issue(BEQ);
    check("ill_pulse", 32'(bus.illegal), 32'd1);
    check("ill_ex_valid", 32'(bus.ex_valid), 32'd0);
    tick();
    check("ill_one_cycle", 32'(bus.illegal), 32'd0);
    bus.ex_ready = 1'b0;
    issue(SUB_4_2_1);
    bus.ex_ready = 1'b1;
    issue(BEQ);
    check("ill2_pulse", 32'(bus.illegal), 32'd1);
    check("ill2_ex_valid", 32'(bus.ex_valid), 32'd0);
    drain();

    // Throughput: 8 random supported ops back to back, one per cycle.
    c0 = cyc;
    for (int n = 0; n < 8; n++) begin
      r = $urandom;
      issue({r[31:7], (r[0] ? 7'b0110011 : 7'b0010011)});
    end
    check("stream_cycles", 32'(cyc - c0), 32'd8);
    drain();

    // Reset with an entry held: discarded, uncounted, registers cleared.
    bus.ex_ready = 1'b0;
    issue(ADD_3_1_2);
    reset          = 1'b1;
    bus.inst_valid = 1'b1;
    bus.inst       = SUB_4_2_1;
    bus.wb_en      = 1'b1;
    bus.wb_rd      = 5'd5;
    bus.wb_data    = 32'h0000_AAAA;
    tick();
    reset          = 1'b0;
    bus.inst_valid = 1'b0;
    bus.wb_en      = 1'b0;
    for (int k = 0; k < 32; k++) regs_m[k] = '0;
    check("mid_rst_valid", 32'(bus.ex_valid), 32'd0);
    check("mid_rst_count", 32'(bus.issue_count), 32'd0);
    check("mid_rst_ready", 32'(bus.inst_ready), 32'd1);
    bus.ex_ready = 1'b1;
    issue(ADD_3_1_2);
    check("post_rst_x1", bus.ex_operand1, 32'd0);
    issue(ADD_6_5_0);
    check("post_rst_x5", bus.ex_operand1, 32'd0);

    // Let everything pending leave, bounded.
    for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_count", 32'(bus.issue_count), 32'(sw_count));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset, synchronous and active-high.
REQ-004 inst_valid  input  1  fetch side presents an instruction.
REQ-005 inst  input  32  RV32 instruction word.
REQ-006 inst_ready  output  1  decoder can accept an instruction this cycle.
REQ-007 wb_en  input  1  register write-back strobe.
REQ-008 wb_rd  input  5  write-back destination register index.
REQ-009 wb_data  input  32  write-back data.
REQ-010 ex_valid  output  1  issue register holds an operation for the ALU.
REQ-011 ex_ready  input  1  ALU side consumes the held operation this cycle.
REQ-012 ex_funct3  output  3  ALU funct3.
REQ-013 ex_funct7  output  7  ALU funct7.
REQ-014 ex_operand1  output  32  ALU operand1 (rs1 value).
REQ-015 ex_operand2  output  32  ALU operand2 (rs2 value or immediate).
REQ-016 ex_rd  output  5  destination register index of the held operation.
REQ-017 illegal  output  1  one-cycle pulse: an unsupported opcode was accepted.
REQ-018 issue_count  output  16  count of operations handed to the ALU.

Function
REQ-019 The block SHALL contain a 32x32 register file; a read of x0 SHALL return 0, and writes to x0 SHALL be ignored.
REQ-020 When wb_en=1, wb_data SHALL be written to wb_rd on the rising edge.
REQ-021 inst_ready SHALL equal (!ex_valid || ex_ready); it is combinational and SHALL NOT depend on inst_valid.
REQ-022 An instruction is accepted when inst_valid && inst_ready && !RESET.
REQ-023 Latency: for a supported opcode accepted in cycle N, ex_valid SHALL be 1 in cycle N+1 with the decoded fields.
REQ-024 Opcode 0110011 (R-type): funct3=inst[14:12], funct7=inst[31:25], operand1=rs1 (inst[19:15]), operand2=rs2 (inst[24:20]), rd=inst[11:7].
REQ-025 Opcode 0010011 (OP-IMM): operand2 SHALL be inst[31:20] sign-extended to 32 bits.
REQ-026 For OP-IMM with funct3 001 or 101, funct7 SHALL be inst[31:25]; for any other OP-IMM funct3, funct7 SHALL be 0000000.
REQ-027 Any other opcode SHALL be accepted and dropped, leaving ex_valid and the issue register unchanged (unless the register is consumed that same cycle), and SHALL raise illegal for exactly one cycle, in cycle N+1.
REQ-028 Bypass: if wb_en=1, wb_rd!=0 and wb_rd matches a source register in the accept cycle, that operand SHALL take wb_data.
REQ-029 While ex_valid=1 and ex_ready=0, all ex_* outputs SHALL hold stable.
REQ-030 If ex_ready=1 and no new supported instruction is accepted that cycle, ex_valid SHALL clear next cycle.
REQ-031 Simultaneous consume and accept SHALL replace the held entry back-to-back with no bubble, giving throughput of 1 per cycle.
REQ-032 issue_count SHALL increment by 1 on each cycle with ex_valid && ex_ready, and SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-033 While RESET=1, the following SHALL be 0 on the next edge: ex_valid, ex_funct3, ex_funct7, ex_operand1, ex_operand2, ex_rd, illegal, issue_count, and all 32 registers.
REQ-034 Reset mid-operation: a pending issue entry SHALL be discarded and not counted; inst and wb inputs in reset cycles SHALL be ignored.
REQ-035 inst_ready SHALL be 1 in the first cycle after RESET deasserts.

Verification
REQ-036 Write x1=5, x2=7, then issue 0x002081B3 (add x3,x1,x2), ex_ready=1 -> next cycle ex_valid=1, funct3=000, funct7=0, operand1=5, operand2=7, rd=3; issue_count=1 after consume.
REQ-037 Issue 0xFFF08093 (addi x1,x1,-1) -> operand2=0xFFFFFFFF, funct7=0; issue srai x1,x1,3 (0x4030D093) -> funct7=0100000, operand2=0x00000403.
REQ-038 Hold ex_ready=0 for 4 cycles with a second inst_valid pending -> inst_ready=0, ex_* stable; raise ex_ready -> second op appears next cycle, no bubble.
REQ-039 In the accept cycle of add x3,x1,x2, drive wb_en=1, wb_rd=1, wb_data=0x12345678 -> operand1=0x12345678; with wb_rd=0 -> operand1 reads 0.
REQ-040 Issue opcode 1100011 -> illegal=1 for one cycle, ex_valid unchanged; assert RESET while ex_valid=1, ex_ready=0 -> ex_valid=0, issue_count=0, and x1 reads 0 afterward.
